// File: rtl/display_uart_tx.sv
// rtl/display_uart_tx.sv - UART 8N1 trace of the display byte as "HH\r\n".
// Every change of the registered display byte is sent as two hex digits plus CR LF.
module display_uart_tx #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] display_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [7:0]    d_q;
  logic [7:0]    last_q;
  logic [7:0]    msg_q;
  logic [1:0]    b_q;
  logic [2:0]    i_q;
  logic [CW-1:0] c_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    byte_d;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    byte_d = 8'h0A;
    case (b_q)
      2'd0:    byte_d = hex_ascii(msg_q[7:4]);
      2'd1:    byte_d = hex_ascii(msg_q[3:0]);
      2'd2:    byte_d = 8'h0D;
      default: byte_d = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      d_q     <= 8'h00;
      last_q  <= 8'h00;
      msg_q   <= 8'h00;
      b_q     <= 2'd0;
      i_q     <= 3'd0;
      c_q     <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      d_q    <= display_i;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (d_q != last_q) begin
            msg_q   <= d_q;
            last_q  <= d_q;
            b_q     <= 2'd0;
            c_q     <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (c_q == C_LAST) begin
            c_q     <= '0;
            i_q     <= 3'd0;
            tx_q    <= byte_d[0];
            state_q <= DATA;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        DATA: begin
          if (c_q == C_LAST) begin
            c_q <= '0;
            if (i_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              i_q  <= i_q + 3'd1;
              tx_q <= byte_d[i_q + 3'd1];
            end
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        STOP: begin
          if (c_q == C_LAST) begin
            c_q <= '0;
            if (b_q == 2'd3) begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              // Next byte's start bit follows the stop bit with no gap.
              b_q     <= b_q + 2'd1;
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: doc/display_uart_tx.md
Name: display_uart_tx

Overview:
- Downstream consumer of the processor's 8-bit display output.
- Watches the display byte and, on every change, sends it over a UART TX line as a 4-byte ASCII message: two uppercase hex digits, CR, LF.
- Gives simulation and FPGA bring-up a serial trace of display activity, without a seven-segment panel.
- Runs in the processor's clock domain.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per UART bit; legal range >= 2; bit counter width $clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- display_i  input  8  display byte from the processor (display_o).
- tx_o  output  1  UART serial output, 8N1, LSB first, idle high.
- busy_o  output  1  high while a message is being shifted out.
- done_o  output  1  one-cycle pulse when a message completes.

Behaviour:
- Reset (synchronous, active-high): on the edge where reset_i=1:
  - tx_o=1, busy_o=0, done_o=0.
  - Input register d_q=8'h00; last-sent register last_q=8'h00; state=IDLE.
- Input sampling: display_i is registered into d_q every cycle, including while busy.

States: IDLE, START, DATA, STOP; byte index b (0..3); bit index i (0..7); baud counter c (0..CLKS_PER_BIT-1).

- IDLE:
  - tx_o=1, busy_o=0.
  - If d_q != last_q: snapshot msg_q<=d_q, last_q<=d_q, b<=0, c<=0, go to START.
- START: tx_o=0 for CLKS_PER_BIT cycles, then DATA with i=0.
- DATA: tx_o=byte[b][i] for CLKS_PER_BIT cycles per bit, i=0..7; after bit 7 go to STOP.
- STOP: tx_o=1 for CLKS_PER_BIT cycles. Then:
  - if b<3: b<=b+1, go to START (no inter-byte gap).
  - if b=3: go to IDLE, done_o=1 for exactly that one cycle.
- busy_o=1 in START, DATA and STOP.

Message bytes:
- byte0 = ASCII hex of msg_q[7:4].
- byte1 = ASCII hex of msg_q[3:0].
- byte2 = 8'h0D; byte3 = 8'h0A.
- Hex mapping: nibble 0-9 -> 8'h30+n; nibble A-F -> 8'h41+(n-10), uppercase.

Timing:
- A display_i change applied before edge N: d_q updates at N; IDLE detects at N+1; tx_o falls after N+1 (first start-bit cycle is cycle N+2).
- Message length is exactly 40*CLKS_PER_BIT cycles of busy_o=1.
- At least one IDLE cycle (tx_o=1, busy_o=0) separates consecutive messages.

Boundary conditions:
- Changes during busy: they do not disturb the current message, because msg_q is frozen. On return to IDLE, d_q is compared with last_q, so only the latest value is sent and intermediate values are dropped.
- A value that changes and returns to last_q before IDLE produces no message.
- A single-cycle glitch on display_i seen while IDLE is captured and sent; there is no debounce.
- Reset mid-message: abort immediately. tx_o=1 on the reset edge, no done_o pulse, last_q cleared. After reset, a nonzero display_i produces a fresh, complete message.
- display_i held at 8'h00 after reset produces no message.

Test Plan (CLKS_PER_BIT=4, 10 ns clock):
1. Reset 2 cycles, display_i=8'h00 for 300 cycles -> tx_o constant 1, busy_o=0, done_o never pulses.
2. display_i=8'h3A -> UART decoder receives 0x33,0x41,0x0D,0x0A. busy_o high exactly 160 cycles; one done_o pulse coincident with busy_o falling; first start bit 2 cycles after the change.
3. display_i=8'h12, then 8'h34 at +20 cycles, then 8'h56 at +40 -> first message "12\r\n" intact, then exactly one message "56\r\n"; 0x34 never transmitted.
4. Sending 8'hC3; mid-message display_i->8'h99, then back to 8'hC3 before the message ends -> only "C3\r\n" sent, tx_o stays 1 afterwards.
5. Reset asserted during DATA of byte1 with display_i=8'hC3 -> tx_o=1, busy_o=0 after that edge, no done_o. After release, a full "C3\r\n" is sent from byte0.
6. Nibble boundaries: 8'h9F -> 0x39,0x46,0x0D,0x0A; then 8'hA0 -> 0x41,0x30,0x0D,0x0A.
